// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage of the pipelined MIPS core.
// Holds the fetch PC and drives the word address to a combinational
// instruction memory. The returned word and its PC+4 are registered into
// the IF/ID slot. Hazard stalls freeze the stage. A redirect from a later
// stage reloads the PC and flushes the IF/ID slot. A saturating counter
// records how many instructions entered IF/ID.
module instruction_fetch_stage #(
  parameter int          ADDR_WIDTH = 7,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          CNT_WIDTH  = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  output logic [ADDR_WIDTH-1:0] Address,
  input  logic [31:0]           Instruction,
  input  logic                  Stall,
  input  logic                  Redirect,
  input  logic [31:0]           RedirectPC,
  output logic [31:0]           PC,
  output logic [31:0]           IF_ID_Instruction,
  output logic [31:0]           IF_ID_PCPlus4,
  output logic                  IF_ID_Valid,
  output logic [CNT_WIDTH-1:0]  FetchCount
);

  // Instruction word used to fill a flushed or reset slot.
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Clears the byte offset so the PC always points at a word boundary.
  // A misaligned target raises no exception.
  function automatic logic [31:0] align_word(input logic [31:0] byte_addr);
    return byte_addr & 32'hFFFF_FFFC;
  endfunction

  // Adds one unless the count is already all-ones, so the count never wraps.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
    logic [CNT_WIDTH-1:0] one;
    one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    return (&cnt) ? cnt : cnt + one;
  endfunction

  // Stage p0: fetch PC. Stage p1: IF/ID slot.
  logic [31:0]          pc_p0;
  logic [31:0]          pc_plus4_p0;
  logic [31:0]          instr_p1;
  logic [31:0]          pc_plus4_p1;
  logic                 vld_p1;
  logic [CNT_WIDTH-1:0] fetch_cnt;

  // ---- stage p0: fetch address and sequential successor ----
  // PC+4 wraps modulo 2^32. Only PC[ADDR_WIDTH+1:2] reaches the memory,
  // so fetches wrap at the memory size while the upper PC bits are kept.
  assign pc_plus4_p0 = pc_p0 + 32'd4;
  assign Address     = pc_p0[ADDR_WIDTH+1:2];

  // PC update: a redirect beats a stall, and a stall beats a normal advance.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_p0 <= RESET_PC;
    end else if (Redirect) begin
      pc_p0 <= align_word(RedirectPC);
    end else if (!Stall) begin
      pc_p0 <= pc_plus4_p0;
    end
  end

  // ---- stage p1: IF/ID slot ----
  // IF/ID load. A redirect discards the word fetched this cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      instr_p1    <= NOP_WORD;
      pc_plus4_p1 <= 32'h0000_0000;
      vld_p1      <= 1'b0;
    end else if (Redirect) begin
      instr_p1    <= NOP_WORD;
      pc_plus4_p1 <= 32'h0000_0000;
      vld_p1      <= 1'b0;
    end else if (!Stall) begin
      instr_p1    <= Instruction;
      pc_plus4_p1 <= pc_plus4_p0;
      vld_p1      <= 1'b1;
    end
  end

  // Debug count of words loaded into IF/ID. Flushed fetches are not counted.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fetch_cnt <= '0;
    end else if (!Redirect && !Stall) begin
      fetch_cnt <= sat_inc(fetch_cnt);
    end
  end

  assign PC                = pc_p0;
  assign IF_ID_Instruction = instr_p1;
  assign IF_ID_PCPlus4     = pc_plus4_p1;
  assign IF_ID_Valid       = vld_p1;
  assign FetchCount        = fetch_cnt;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Testbench for instruction_fetch_stage.
// A table of directed vectors runs first. A randomised run checked
// against a behavioural model follows. The last part uses a narrow-counter
// build to check that FetchCount saturates.
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT uses the default parameters.
  logic        rst, stall, redir;
  logic [31:0] rpc;
  logic [6:0]  addr;
  logic [31:0] instr, pc, ifid_ins, ifid_p4;
  logic        ifid_v;
  logic [15:0] cnt;

  assign instr = 32'hA000_0000 | {25'b0, addr};

  instruction_fetch_stage dut (
    .Clk(clk), .Reset(rst), .Address(addr), .Instruction(instr),
    .Stall(stall), .Redirect(redir), .RedirectPC(rpc), .PC(pc),
    .IF_ID_Instruction(ifid_ins), .IF_ID_PCPlus4(ifid_p4),
    .IF_ID_Valid(ifid_v), .FetchCount(cnt)
  );

  // Second DUT has a 4-bit counter so that saturation is reached quickly.
  logic        rst2, stall2, redir2;
  logic [31:0] rpc2;
  logic [6:0]  addr2;
  logic [31:0] instr2, pc2, ifid_ins2, ifid_p42;
  logic        ifid_v2;
  logic [3:0]  cnt2;

  assign instr2 = 32'hA000_0000 | {25'b0, addr2};

  instruction_fetch_stage #(.CNT_WIDTH(4)) dut4 (
    .Clk(clk), .Reset(rst2), .Address(addr2), .Instruction(instr2),
    .Stall(stall2), .Redirect(redir2), .RedirectPC(rpc2), .PC(pc2),
    .IF_ID_Instruction(ifid_ins2), .IF_ID_PCPlus4(ifid_p42),
    .IF_ID_Valid(ifid_v2), .FetchCount(cnt2)
  );

  typedef struct {
    logic [31:0] pc, ins, p4;
    logic        v;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    logic        rst, stall, redir;
    logic [31:0] rpc;
    logic        chk_addr;
    logic [6:0]  addr;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, s, d, input logic [31:0] rp,
                              input logic ca, input logic [6:0] a,
                              input logic [31:0] epc, eins, ep4,
                              input logic ev, input logic [15:0] ecnt);
    vec_t t;
    t.rst = r; t.stall = s; t.redir = d; t.rpc = rp; t.chk_addr = ca; t.addr = a;
    t.e.pc = epc; t.e.ins = eins; t.e.p4 = ep4; t.e.v = ev; t.e.cnt = ecnt;
    return t;
  endfunction

  // Drive one cycle, optionally check the combinational address, queue the
  // expected post-edge state, then pop it and compare after the edge.
  task automatic apply(input string tag, input vec_t t);
    exp_t got;
    @(negedge clk);
    rst = t.rst; stall = t.stall; redir = t.redir; rpc = t.rpc;
    #1;
    if (t.chk_addr) chk({tag, ".addr"}, {25'b0, addr}, {25'b0, t.addr});
    sb.push_back(t.e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      chk({tag, ".pc"},  pc,       got.pc);
      chk({tag, ".ins"}, ifid_ins, got.ins);
      chk({tag, ".p4"},  ifid_p4,  got.p4);
      chk({tag, ".v"},   {31'b0, ifid_v}, {31'b0, got.v});
      chk({tag, ".cnt"}, {16'b0, cnt},    {16'b0, got.cnt});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] mpc, mins, mp4;
    logic        mv;
    logic [15:0] mcnt;
    vec_t        t;

    rst = 1'b1; stall = 1'b0; redir = 1'b0; rpc = 32'h0;
    rst2 = 1'b1; stall2 = 1'b0; redir2 = 1'b0; rpc2 = 32'h0;

    // Directed vectors: rst stall redir rpc | chk addr | pc ins p4 v cnt
    vecs.push_back(mk(1,0,0,32'h0,   0,7'h00, 32'h0,   32'h0,        32'h0,   0,0));
    // Free-running fetch after reset.
    vecs.push_back(mk(0,0,0,32'h0,   1,7'h00, 32'h4,   32'hA0000000, 32'h4,   1,1));
    vecs.push_back(mk(0,0,0,32'h0,   1,7'h01, 32'h8,   32'hA0000001, 32'h8,   1,2));
    vecs.push_back(mk(0,0,0,32'h0,   1,7'h02, 32'hC,   32'hA0000002, 32'hC,   1,3));
    vecs.push_back(mk(0,0,0,32'h0,   1,7'h03, 32'h10,  32'hA0000003, 32'h10,  1,4));
    // Reset mid-stream with stall and redirect also high.
    vecs.push_back(mk(1,1,1,32'h80,  1,7'h04, 32'h0,   32'h0,        32'h0,   0,0));
    vecs.push_back(mk(0,0,0,32'h0,   1,7'h00, 32'h4,   32'hA0000000, 32'h4,   1,1));
    vecs.push_back(mk(0,0,0,32'h0,   1,7'h01, 32'h8,   32'hA0000001, 32'h8,   1,2));
    // Two-cycle stall at PC=0x8.
    vecs.push_back(mk(0,1,0,32'h0,   1,7'h02, 32'h8,   32'hA0000001, 32'h8,   1,2));
    vecs.push_back(mk(0,1,0,32'h0,   1,7'h02, 32'h8,   32'hA0000001, 32'h8,   1,2));
    vecs.push_back(mk(0,0,0,32'h0,   1,7'h02, 32'hC,   32'hA0000002, 32'hC,   1,3));
    // Redirect to 0x40.
    vecs.push_back(mk(0,0,1,32'h40,  1,7'h03, 32'h40,  32'h0,        32'h0,   0,3));
    vecs.push_back(mk(0,0,0,32'h0,   1,7'h10, 32'h44,  32'hA0000010, 32'h44,  1,4));
    // Redirect and stall together; the misaligned target is aligned.
    vecs.push_back(mk(0,1,1,32'h103, 1,7'h11, 32'h100, 32'h0,        32'h0,   0,4));
    vecs.push_back(mk(0,0,0,32'h0,   1,7'h40, 32'h104, 32'hA0000040, 32'h104, 1,5));
    // Address wrap at the top of the 128-word memory.
    vecs.push_back(mk(0,0,1,32'h1F8, 1,7'h41, 32'h1F8, 32'h0,        32'h0,   0,5));
    vecs.push_back(mk(0,0,0,32'h0,   1,7'h7E, 32'h1FC, 32'hA000007E, 32'h1FC, 1,6));
    vecs.push_back(mk(0,0,0,32'h0,   1,7'h7F, 32'h200, 32'hA000007F, 32'h200, 1,7));
    vecs.push_back(mk(0,0,0,32'h0,   1,7'h00, 32'h204, 32'hA0000000, 32'h204, 1,8));
    // PC+4 wraps modulo 2^32.
    vecs.push_back(mk(0,0,1,32'hFFFFFFFE,1,7'h01,32'hFFFFFFFC,32'h0, 32'h0,   0,8));
    vecs.push_back(mk(0,0,0,32'h0,   1,7'h7F, 32'h0,   32'hA000007F, 32'h0,   1,9));
    vecs.push_back(mk(0,0,0,32'h0,   1,7'h00, 32'h4,   32'hA0000000, 32'h4,   1,10));
    // Back-to-back redirects; the second target wins.
    vecs.push_back(mk(0,0,1,32'h300, 1,7'h01, 32'h300, 32'h0,        32'h0,   0,10));
    vecs.push_back(mk(0,0,1,32'h10,  1,7'h40, 32'h10,  32'h0,        32'h0,   0,10));
    vecs.push_back(mk(0,0,0,32'h0,   1,7'h04, 32'h14,  32'hA0000004, 32'h14,  1,11));
    // A stall on a flushed slot keeps the slot's contents unchanged.
    vecs.push_back(mk(0,0,1,32'h20,  1,7'h05, 32'h20,  32'h0,        32'h0,   0,11));
    vecs.push_back(mk(0,1,0,32'h0,   1,7'h08, 32'h20,  32'h0,        32'h0,   0,11));

    for (int i = 0; i < vecs.size(); i++) apply($sformatf("vec%0d", i), vecs[i]);

    // Randomised run against a behavioural model. It starts from reset.
    mpc = 32'h0; mins = 32'h0; mp4 = 32'h0; mv = 1'b0; mcnt = 16'h0;
    t = mk(1,0,0,32'h0, 0,7'h0, mpc, mins, mp4, mv, mcnt);
    apply("rnd_rst", t);
    for (int i = 0; i < 300; i++) begin
      t.rst      = ($urandom_range(0, 39) == 0);
      t.stall    = ($urandom_range(0, 3) == 0);
      t.redir    = ($urandom_range(0, 5) == 0);
      t.rpc      = $urandom;
      t.chk_addr = 1'b1;
      t.addr     = mpc[8:2];
      if (t.rst) begin
        mpc = 32'h0; mins = 32'h0; mp4 = 32'h0; mv = 1'b0; mcnt = 16'h0;
      end else if (t.redir) begin
        mpc = {t.rpc[31:2], 2'b00}; mins = 32'h0; mp4 = 32'h0; mv = 1'b0;
      end else if (!t.stall) begin
        mins = 32'hA000_0000 | {25'b0, t.addr};
        mp4  = mpc + 32'd4;
        mv   = 1'b1;
        mpc  = mpc + 32'd4;
        if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
      end
      t.e.pc = mpc; t.e.ins = mins; t.e.p4 = mp4; t.e.v = mv; t.e.cnt = mcnt;
      apply($sformatf("rnd%0d", i), t);
    end
    chk("sb_empty", sb.size(), 32'd0);

    // Narrow-counter build: the count climbs to 0xF and then stays there.
    @(negedge clk); rst2 = 1'b1;
    @(posedge clk); #1;
    chk("cnt4_rst", {28'b0, cnt2}, 32'd0);
    @(negedge clk); rst2 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      chk($sformatf("cnt4_%0d", i), {28'b0, cnt2}, (i > 15) ? 32'd15 : i);
    end
    chk("cnt4_pc", pc2, 32'd80);
    // Reset together with stall and redirect clears the saturated count.
    @(negedge clk); rst2 = 1'b1; stall2 = 1'b1; redir2 = 1'b1; rpc2 = 32'h44;
    @(posedge clk); #1;
    chk("cnt4_rst2", {28'b0, cnt2}, 32'd0);
    chk("cnt4_rst2_pc", pc2, 32'd0);
    chk("cnt4_rst2_v", {31'b0, ifid_v2}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- IF stage of the pipelined MIPS core; drives the word address into the InstructionMemory and consumes the returned 32-bit Instruction.
- Holds the PC and registers the fetched word plus PC+4 into the IF/ID pipeline register.
- Honours hazard-unit stalls and branch/jump redirects from later stages (flush of the IF/ID slot).
- Keeps a saturating count of retired fetches for debug.

Parameters:
- ADDR_WIDTH, 7, word-address width into InstructionMemory (128 words)
- RESET_PC, 32'h0000_0000, byte PC loaded on reset (bits [1:0] must be 0)
- CNT_WIDTH, 16, width of FetchCount

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- Address  output  ADDR_WIDTH  word address to InstructionMemory = PC[ADDR_WIDTH+1:2], combinational from PC
- Instruction  input  32  word returned combinationally by InstructionMemory for Address
- Stall  input  1  hazard unit: hold PC and IF/ID
- Redirect  input  1  branch taken / jump resolved in a later stage
- RedirectPC  input  32  target byte address for Redirect
- PC  output  32  current fetch PC (byte address)
- IF_ID_Instruction  output  32  registered instruction
- IF_ID_PCPlus4  output  32  registered PC+4 of that instruction
- IF_ID_Valid  output  1  IF/ID slot holds a real instruction
- FetchCount  output  CNT_WIDTH  number of instructions loaded into IF/ID, saturating

Behaviour:
- One clock (Clk); reset is synchronous and active-high (Reset); all state updates on rising Clk.
- Reset (highest priority, also mid-operation): PC<=RESET_PC, IF_ID_Instruction<=32'h0 (NOP), IF_ID_PCPlus4<=0, IF_ID_Valid<=0, FetchCount<=0. Inputs are ignored in the reset cycle.
- Memory read is combinational: Instruction for Address is valid in the same cycle. IF/ID latency is one cycle from PC to IF_ID_*.
- Priority per edge: Reset > Redirect > Stall > normal.
- Normal (no Stall, no Redirect):
  - IF_ID_Instruction<=Instruction
  - IF_ID_PCPlus4<=PC+4
  - IF_ID_Valid<=1
  - PC<=PC+4
  - FetchCount<=FetchCount+1, saturating at all-ones
- Stall without Redirect: PC, IF_ID_* and FetchCount hold their values.
- Redirect (with or without Stall): PC<={RedirectPC[31:2],2'b00}; IF_ID_Instruction<=0, IF_ID_Valid<=0, IF_ID_PCPlus4<=0; FetchCount unchanged. The word fetched in that cycle is discarded.
- Arithmetic: PC+4 is 32-bit, modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
- Address uses only PC[ADDR_WIDTH+1:2], so fetches wrap at memory size (PC 0x1FC -> Address 127; PC 0x200 -> Address 0). PC[31:ADDR_WIDTH+2] is kept intact.
- RedirectPC[1:0] is forced to 0, with no exception.
- FetchCount at 0xFFFF stays 0xFFFF.
- Back-to-back Redirects: each one loads a new PC and flushes; the latest one wins.
- No X propagation: every register has a defined reset value.

Test Plan:
- The bench models memory as Instruction = 32'hA000_0000 | Address.
1. Reset then 4 free-running cycles -> Address 0,1,2,3; one cycle later IF_ID_Instruction = A0000000, A0000001, A0000002, A0000003; IF_ID_PCPlus4 = 4, 8, C, 10; Valid=1; FetchCount=4.
2. At PC=0x8 assert Stall for 2 cycles -> PC stays 0x8, IF_ID holds A0000001 / PCPlus4=8, FetchCount frozen; after release the next IF_ID is A0000002.
3. At PC=0xC pulse Redirect with RedirectPC=0x40 -> next edge PC=0x40, IF_ID_Valid=0, IF_ID_Instruction=0; following edge IF_ID_Instruction=A0000010, PCPlus4=0x44.
4. Redirect and Stall together with RedirectPC=0x103 -> PC=0x100 (alignment forced), slot flushed; Address=0x40 next cycle.
5. Run through PC=0x1FC -> Address 127 then 0 at PC=0x200, with IF_ID_PCPlus4=0x200 then 0x204. Force PC to 0xFFFF_FFFC via Redirect and verify PC+4 wraps to 0.
6. Assert Reset mid-stream with Stall and Redirect also high -> next edge all outputs at reset values and PC=RESET_PC. Preload FetchCount near 0xFFFF (CNT_WIDTH=4 build) and verify it saturates at 0xF.
